// File: rtl/arb_defs.sv
// Shared state/mode encodings and elaboration helpers for the bus arbiter.
package arb_defs;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_TURN  = 2'd2
   } arb_state_t;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;

   function automatic int arb_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/arb_rotate_pick.sv
// Combinational rotating priority pick: first eligible request at or above start, wrapping.
// start = 0 degenerates to fixed priority with index 0 highest.
module arb_rotate_pick
   import arb_defs::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   start,
   input  logic [N_REQ-1:0] mask,
   output logic [IDW-1:0]   winner,
   output logic             any_vld
);

   logic [N_REQ-1:0] elig;

   assign elig = req & mask;

   // Scan from the farthest offset down so the nearest eligible index wins last.
   always_comb begin
      winner  = '0;
      any_vld = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (elig[(int'(start) + i) % N_REQ]) begin
            winner  = IDW'((int'(start) + i) % N_REQ);
            any_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_nch.sv
// N-requester shared-bus arbiter, fixed or round-robin, registered one-hot grant.
// Latency: grant 1 cycle after request seen in IDLE; release costs 1 + TURNAROUND cycles.
// No preemption: owner keeps the bus while req|hold; ARB_TIMEOUT_EN bounds tenure.
module bus_arbiter_nch
   import arb_defs::*;
#(
   parameter int N_REQ          = 4,
   parameter int IDW            = 2,
   parameter int TURNAROUND     = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] hold,
   input  logic             mode,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   grant_id,
   output logic             bus_busy,
   output logic             timeout,
   output logic [IDW-1:0]   timeout_id
);

   if (IDW < arb_clog2(N_REQ) || N_REQ < 2 || N_REQ > 8) begin : g_bad_width
      $error("bus_arbiter_nch: N_REQ out of range or IDW too narrow");
   end
   if (TURNAROUND < 0 || TURNAROUND > 3 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
      $error("bus_arbiter_nch: TURNAROUND or TIMEOUT_CYCLES out of range");
   end

   localparam logic [1:0] TURN_LOAD = 2'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [1:0]       turn_q, turn_d;
   logic [N_REQ-1:0] pick_mask;
   logic [IDW-1:0]   pick_start;
   logic [IDW-1:0]   winner;
   logic             any_vld;
   logic             keep;
   logic             force_off;

   assign keep       = req[id_q] | hold[id_q];
   assign pick_start = (mode == ARB_MODE_RR) ? rr_q : '0;

`ifdef ARB_TIMEOUT_EN
   localparam int TW = arb_clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0]    tenure_q, tenure_d;
   logic [N_REQ-1:0] excl_q, excl_d;
   logic             timeout_q, timeout_d;
   logic [IDW-1:0]   timeout_id_q, timeout_id_d;

   // A timed-out master sits out one decision unless it is the only one asking.
   assign pick_mask  = ((req & ~excl_q) != '0) ? ~excl_q : '1;
   assign force_off  = (tenure_q == TW'(TIMEOUT_CYCLES - 1));
   assign timeout    = timeout_q;
   assign timeout_id = timeout_id_q;
`else
   assign pick_mask  = '1;
   assign force_off  = 1'b0;
   assign timeout    = 1'b0;
   assign timeout_id = '0;
`endif

   arb_rotate_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
      .req     (req),
      .start   (pick_start),
      .mask    (pick_mask),
      .winner  (winner),
      .any_vld (any_vld)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      rr_d    = rr_q;
      turn_d  = turn_q;
`ifdef ARB_TIMEOUT_EN
      tenure_d     = tenure_q;
      excl_d       = excl_q;
      timeout_d    = 1'b0;
      timeout_id_d = timeout_id_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (any_vld) begin
               grant_d = N_REQ'(1) << winner;
               id_d    = winner;
               state_d = ARB_GRANT;
               if (mode == ARB_MODE_RR)
                  rr_d = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
`ifdef ARB_TIMEOUT_EN
               tenure_d = '0;
               excl_d   = '0;
`endif
            end
         end
         ARB_GRANT: begin
            if (!keep || force_off) begin
               grant_d = '0;
               if (TURNAROUND == 0) begin
                  state_d = ARB_IDLE;
               end else begin
                  state_d = ARB_TURN;
                  turn_d  = TURN_LOAD;
               end
`ifdef ARB_TIMEOUT_EN
               if (keep) begin
                  timeout_d    = 1'b1;
                  timeout_id_d = id_q;
                  excl_d       = grant_q;
               end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               tenure_d = tenure_q + 1'b1;
            end
`endif
         end
         ARB_TURN: begin
            if (turn_q == 2'd0) state_d = ARB_IDLE;
            else                turn_d  = turn_q - 2'd1;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         id_q    <= '0;
         rr_q    <= '0;
         turn_q  <= '0;
`ifdef ARB_TIMEOUT_EN
         tenure_q     <= '0;
         excl_q       <= '0;
         timeout_q    <= 1'b0;
         timeout_id_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         turn_q  <= turn_d;
`ifdef ARB_TIMEOUT_EN
         tenure_q     <= tenure_d;
         excl_q       <= excl_d;
         timeout_q    <= timeout_d;
         timeout_id_q <= timeout_id_d;
`endif
      end
   end

   assign grant    = grant_q;
   assign grant_id = id_q;
   assign bus_busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_bus_arbiter_nch.sv
// Randomised and directed bench for bus_arbiter_nch against a tenure-level reference model.
module tb_bus_arbiter_nch;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TA  = 1;
   localparam int TO  = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   hold;
   logic           mode;
   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic           bus_busy;
   logic           timeout;
   logic [IDW-1:0] timeout_id;

   bus_arbiter_nch #(
      .N_REQ(N), .IDW(IDW), .TURNAROUND(TA), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .hold       (hold),
      .mode       (mode),
      .grant      (grant),
      .grant_id   (grant_id),
      .bus_busy   (bus_busy),
      .timeout    (timeout),
      .timeout_id (timeout_id)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, how many dead cycles remain, and bookkeeping.
   int m_owner;   // -1 when nobody holds the bus
   int m_gap;     // remaining turnaround cycles after a release
   int m_id;
   int m_rr;
   int m_ten;     // granted cycles so far minus one
   int m_excl;    // master barred from the next decision, -1 none
   int m_to;
   int m_to_id;

   task automatic model_reset();
      m_owner = -1; m_gap = 0; m_id = 0; m_rr = 0;
      m_ten = 0; m_excl = -1; m_to = 0; m_to_id = 0;
   endtask

   task automatic model_edge();
      int  cand[$];
      int  best;
      bit  keep;
      bit  expired;
      m_to = 0;
      if (m_owner >= 0) begin
         keep    = req[m_owner] | hold[m_owner];
         expired = 1'b0;
`ifdef ARB_TIMEOUT_EN
         expired = (m_ten + 1 >= TO);
`endif
         if (!keep || expired) begin
            if (keep) begin
               m_to = 1; m_to_id = m_owner; m_excl = m_owner;
            end
            m_owner = -1;
            m_gap   = TA;
         end else begin
            m_ten++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req != '0) begin
         for (int i = 0; i < N; i++) if (req[i] && i != m_excl) cand.push_back(i);
         if (cand.size() == 0)
            for (int i = 0; i < N; i++) if (req[i]) cand.push_back(i);
         best = cand[0];
         if (mode) begin
            foreach (cand[k])
               if ((cand[k] - m_rr + N) % N < (best - m_rr + N) % N) best = cand[k];
            m_rr = (best + 1) % N;
         end
         m_owner = best; m_id = best; m_ten = 0; m_excl = -1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] eg;
      if (m_owner >= 0) eg = N'(1) << m_owner;
      else              eg = '0;
      check_eq({tag, ".grant"},      32'(grant),      32'(eg));
      check_eq({tag, ".grant_id"},   32'(grant_id),   32'(m_id));
      check_eq({tag, ".bus_busy"},   32'(bus_busy),   32'((m_owner >= 0) || (m_gap > 0)));
      check_eq({tag, ".timeout"},    32'(timeout),    32'(m_to));
      check_eq({tag, ".timeout_id"}, 32'(timeout_id), 32'(m_to_id));
   endtask

   task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] h,
                       input logic md);
      req = r; hold = h; mode = md;
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step("rst", '0, '0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] rv;
      logic [N-1:0] prev_g;
      logic [N-1:0] order[$];
      logic [N-1:0] exp_ord[5];

      reset = 1'b1; req = '0; hold = '0; mode = 1'b0;
      model_reset();
      #1;
      check_eq("reset.grant", 32'(grant), 32'h0);
      check_eq("reset.busy",  32'(bus_busy), 32'h0);
      step("rst", '0, '0, 1'b0);
      reset = 1'b0;
      step("idle", '0, '0, 1'b0);

      // Fixed priority and release timing.
      step("fix", 4'b1010, '0, 1'b0);
      check_eq("fix.grant", 32'(grant), 32'h2);
      check_eq("fix.id",    32'(grant_id), 32'h1);
      step("fix_rel", 4'b1000, '0, 1'b0);
      check_eq("fix_rel.grant", 32'(grant), 32'h0);
      check_eq("fix_rel.busy",  32'(bus_busy), 32'h1);
      step("fix_idle", 4'b1000, '0, 1'b0);
      check_eq("fix_idle.busy", 32'(bus_busy), 32'h0);
      step("fix_next", 4'b1000, '0, 1'b0);
      check_eq("fix_next.grant", 32'(grant), 32'h8);

      // Asynchronous reset in the middle of a tenure.
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst.grant",   32'(grant), 32'h0);
      check_eq("async_rst.busy",    32'(bus_busy), 32'h0);
      check_eq("async_rst.timeout", 32'(timeout), 32'h0);
      model_reset();
      step("rst_hold", 4'b1000, '0, 1'b0);
      reset = 1'b0;
      step("rst_req", 4'b0001, '0, 1'b0);
      check_eq("rst_req.grant", 32'(grant), 32'h1);

      // Round-robin rotation; each owner drops req in its second granted cycle.
      reset_pulse();
      exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      prev_g  = '0;
      for (int c = 0; c < 80 && order.size() < 5; c++) begin
         rv = 4'b1111;
         if (m_owner >= 0 && m_ten >= 1) rv[m_owner] = 1'b0;
         step("rr", rv, '0, 1'b1);
         if (grant != '0 && prev_g == '0) order.push_back(grant);
         prev_g = grant;
      end
      check_eq("rr.count", 32'(order.size()), 32'd5);
      foreach (order[k]) check_eq($sformatf("rr.order%0d", k), 32'(order[k]), 32'(exp_ord[k]));

      // Hold keeps the bus after req drops.
      reset_pulse();
      step("hold_get", 4'b0100, '0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step("hold", 4'b0001, 4'b0100, 1'b0);
         check_eq($sformatf("hold.grant%0d", c), 32'(grant), 32'h4);
      end
      step("hold_rel", 4'b0001, '0, 1'b0);
      check_eq("hold_rel.grant", 32'(grant), 32'h0);
      step("hold_turn", 4'b0001, '0, 1'b0);
      step("hold_next", 4'b0001, '0, 1'b0);
      check_eq("hold_next.grant", 32'(grant), 32'h1);

      // Mode flipped mid-tenure only matters at the next decision.
      reset_pulse();
      step("mc_rr", 4'b0010, '0, 1'b1);
      step("mc_rr_rel", '0, '0, 1'b1);
      step("mc_t", '0, '0, 1'b1);
      step("mc_own", 4'b1000, 4'b1000, 1'b0);
      check_eq("mc_own.grant", 32'(grant), 32'h8);
      for (int c = 0; c < 3; c++) begin
         step("mc_hold", 4'b0110, 4'b1000, 1'b1);
         check_eq($sformatf("mc_hold.grant%0d", c), 32'(grant), 32'h8);
      end
      step("mc_rel", 4'b0110, '0, 1'b1);
      step("mc_turn", 4'b0110, '0, 1'b1);
      step("mc_next", 4'b0110, '0, 1'b1);
      check_eq("mc_next.grant", 32'(grant), 32'h4);

`ifdef ARB_TIMEOUT_EN
      // Forced release after TO cycles; the timed-out master sits out once.
      reset_pulse();
      step("to_get", 4'b0011, 4'b0001, 1'b0);
      for (int c = 0; c < TO - 1; c++) begin
         step("to_hold", 4'b0011, 4'b0001, 1'b0);
         check_eq($sformatf("to_hold.grant%0d", c), 32'(grant), 32'h1);
      end
      step("to_fire", 4'b0011, 4'b0001, 1'b0);
      check_eq("to_fire.grant",   32'(grant), 32'h0);
      check_eq("to_fire.timeout", 32'(timeout), 32'h1);
      check_eq("to_fire.id",      32'(timeout_id), 32'h0);
      step("to_turn", 4'b0011, 4'b0001, 1'b0);
      check_eq("to_turn.timeout", 32'(timeout), 32'h0);
      step("to_next", 4'b0011, 4'b0001, 1'b0);
      check_eq("to_next.grant", 32'(grant), 32'h2);
`endif

      // Random traffic with occasional resets and mode changes.
      reset_pulse();
      mode = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         logic [N-1:0] rr_v;
         logic [N-1:0] hh_v;
         logic         md_v;
         rr_v = N'($urandom_range(0, 15));
         hh_v = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
         md_v = ($urandom_range(0, 15) == 0) ? ~mode : mode;
         if ($urandom_range(0, 99) == 0) reset = 1'b1;
         step("rand", rr_v, hh_v, md_v);
         reset = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
